// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: observes a 4-digit multiplexed, active-low 7-segment bus and
// recovers the hex nibble, decimal point and valid flag shown on each digit.
// The bus is asynchronous to clk; both halves are synchronised with two flops.
// Optional feature macro: SEG7_TIMEOUT_EN (per-digit refresh timeout on digit_valid).
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  signal,
    input  logic [3:0]  selector,
    output logic [15:0] hex,
    output logic [3:0]  dp,
    output logic [3:0]  digit_valid,
    output logic        update,
    output logic        pattern_err
);

    localparam int unsigned NDIG  = 4;
    localparam int unsigned SEG_W = 8;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned SMP_W = SEL_W + SEG_W;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Reject configurations the stability filter cannot honour.
    if (STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("seg7_scan_decoder: STABLE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [SEG_W-1:0] sig_m, sig_q;
    logic [SEL_W-1:0] sel_m, sel_q;
    logic [SMP_W-1:0] sample_c;
    logic [SMP_W-1:0] prev_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blank_c;
    logic             same_c;
    logic             capture_c;
    logic [3:0]       cap_nib_c;
    logic             cap_legal_c;
    logic [NDIG-1:0]  cap_digit_c;

    // Map a 7-segment pattern (active-low, g..a) to {legal, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b0_0000;
        case (seg)
            7'h40: r = 5'b1_0000;
            7'h79: r = 5'b1_0001;
            7'h24: r = 5'b1_0010;
            7'h30: r = 5'b1_0011;
            7'h19: r = 5'b1_0100;
            7'h12: r = 5'b1_0101;
            7'h02: r = 5'b1_0110;
            7'h78: r = 5'b1_0111;
            7'h00: r = 5'b1_1000;
            7'h10: r = 5'b1_1001;
            7'h08: r = 5'b1_1010;
            7'h03: r = 5'b1_1011;
            7'h46: r = 5'b1_1100;
            7'h21: r = 5'b1_1101;
            7'h06: r = 5'b1_1110;
            7'h0E: r = 5'b1_1111;
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Two-flop synchronisers; reset to the blank bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_m <= '1;
            sig_q <= '1;
            sel_m <= '1;
            sel_q <= '1;
        end else begin
            sig_m <= signal;
            sig_q <= sig_m;
            sel_m <= selector;
            sel_q <= sel_m;
        end
    end

    assign sample_c = {sel_q, sig_q};
    assign blank_c  = (sel_q == '1);
    assign same_c   = (sample_c == prev_q);

    // State, run counter and the previous synced sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= sample_c;
        end
    end

    // Next state: count identical samples; capture once the run reaches STABLE_CYCLES.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!blank_c) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(1);
                end
            end
            SETTLE: begin
                capture_c = (cnt_q == CNT_W'(STABLE_CYCLES));
                if (blank_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same_c) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (blank_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same_c) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The captured sample is the one the run was counted on (previous cycle).
    always_comb begin
        {cap_legal_c, cap_nib_c} = decode(prev_q[6:0]);
        for (int i = 0; i < NDIG; i++) begin
            cap_digit_c[i] = capture_c && !prev_q[SEG_W + i];
        end
    end

`ifdef SEG7_TIMEOUT_EN
    localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NDIG-1:0][AGE_W-1:0] age_q;
    logic [NDIG-1:0]            timeout_c;

    // Per-digit age since last capture, saturating at TIMEOUT_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (cap_digit_c[i]) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != AGE_W'(TIMEOUT_CYCLES)) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    // Timeout fires on the edge where the age reaches TIMEOUT_CYCLES (and after).
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            timeout_c[i] = (age_q[i] >= AGE_W'(TIMEOUT_CYCLES - 1));
        end
    end
`endif

    // Output registers: write captured digits, sticky error, one-cycle update pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex         <= '0;
            dp          <= '0;
            digit_valid <= '0;
            update      <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            update <= capture_c;
            if (capture_c && !cap_legal_c) begin
                pattern_err <= 1'b1;
            end
            for (int i = 0; i < NDIG; i++) begin
                if (cap_digit_c[i]) begin
                    if (cap_legal_c) begin
                        hex[4*i +: 4]  <= cap_nib_c;
                        dp[i]          <= ~prev_q[7];
                        digit_valid[i] <= 1'b1;
                    end else begin
                        digit_valid[i] <= 1'b0;
                    end
                end
`ifdef SEG7_TIMEOUT_EN
                else if (timeout_c[i]) begin
                    digit_valid[i] <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios with literal
// expectations plus randomized bus activity checked every cycle against a
// run-length model of the synchronised bus.
module tb_seg7_scan_decoder;

    localparam int unsigned STABLE  = 4;
    localparam int unsigned TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  signal = 8'hFF;
    logic [3:0]  selector = 4'hF;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  digit_valid;
    logic        update;
    logic        pattern_err;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .signal     (signal),
        .selector   (selector),
        .hex        (hex),
        .dp         (dp),
        .digit_valid(digit_valid),
        .update     (update),
        .pattern_err(pattern_err)
    );

    // Segment code for each hex value 0..F (active-low, g..a).
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [11:0] m_s1, m_s2, m_last, m_cap, s;
    int          m_run;
    bit          m_pend;
    logic [15:0] e_hex;
    logic [3:0]  e_dp, e_valid;
    logic        e_upd, e_err;
    int          m_age [4];
    int          m_nib;

    // Pins go through two sample delays; a capture is due the edge after a run of
    // identical non-blank samples first reaches STABLE.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1; m_last = '1; m_cap = '1;
            m_run = 0; m_pend = 0;
            e_hex = '0; e_dp = '0; e_valid = '0; e_upd = 1'b0; e_err = 1'b0;
            for (int i = 0; i < 4; i++) m_age[i] = 0;
        end else begin
            m_nib = -1;
            for (int v = 0; v < 16; v++) if (seg_tbl[v] == m_cap[6:0]) m_nib = v;
            e_upd = m_pend;
            if (m_pend && m_nib < 0) e_err = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (m_pend && !m_cap[8+i]) begin
                    m_age[i] = 0;
                    if (m_nib >= 0) begin
                        e_hex[4*i +: 4] = 4'(m_nib);
                        e_dp[i]         = ~m_cap[7];
                        e_valid[i]      = 1'b1;
                    end else begin
                        e_valid[i] = 1'b0;
                    end
                end else begin
                    if (m_age[i] < TIMEOUT) m_age[i]++;
`ifdef SEG7_TIMEOUT_EN
                    if (m_age[i] == TIMEOUT) e_valid[i] = 1'b0;
`endif
                end
            end
            s = m_s2;
            if (s[11:8] == 4'hF) m_run = 0;
            else if (m_run > 0 && s == m_last) m_run = (m_run > STABLE) ? m_run : m_run + 1;
            else m_run = 1;
            m_last = s;
            m_pend = (m_run == STABLE);
            m_cap  = s;
            m_s2 = m_s1;
            m_s1 = {selector, signal};
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("hex", 32'(hex), 32'(e_hex));
            chk("dp", 32'(dp), 32'(e_dp));
            chk("digit_valid", 32'(digit_valid), 32'(e_valid));
            chk("update", 32'(update), 32'(e_upd));
            chk("pattern_err", 32'(pattern_err), 32'(e_err));
            if (update === 1'b1) upd_cnt++;
        end
    end

    task automatic drive(input logic [3:0] sel, input logic [7:0] sg, input int n);
        selector = sel;
        signal   = sg;
        repeat (n) @(negedge clk);
    endtask

    int t_cap, t_drop, r;
    logic [3:0] rsel;
    logic [7:0] rsig;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hex", 32'(hex), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_update", 32'(update), 32'h0);
        chk("rst_err", 32'(pattern_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single digit, exact latency 2+4+1
        upd_cnt = 0;
        drive(4'b1110, 8'hA4, 6);
        #1;
        chk("t1_no_early_update", 32'(update), 32'h0);
        chk("t1_no_early_hex", 32'(hex), 32'h0);
        @(negedge clk);
        #1;
        chk("t1_update", 32'(update), 32'h1);
        chk("t1_hex0", 32'(hex[3:0]), 32'h2);
        chk("t1_dp0", 32'(dp[0]), 32'h0);
        chk("t1_valid", 32'(digit_valid), 32'h1);
        drive(4'b1110, 8'hA4, 10);
        #1;
        chk("t1_one_pulse", 32'(upd_cnt), 32'h1);

        // 2: all selects low, one shared pattern
        upd_cnt = 0;
        drive(4'b0000, 8'h0E, 12);
        #1;
        chk("t2_hex", 32'(hex), 32'hFFFF);
        chk("t2_valid", 32'(digit_valid), 32'hF);
        chk("t2_one_pulse", 32'(upd_cnt), 32'h1);

        // 3: two full scans
        upd_cnt = 0;
        for (int sc = 0; sc < 2; sc++) begin
            drive(4'b1110, 8'hF9, 20);
            drive(4'b1101, 8'h24, 20);
            drive(4'b1011, 8'h30, 20);
            drive(4'b0111, 8'h19, 20);
        end
        #1;
        chk("t3_hex", 32'(hex), 32'h4321);
        chk("t3_valid", 32'(digit_valid), 32'hF);
        chk("t3_pulses", 32'(upd_cnt), 32'd8);

        // 4: short glitch is filtered
        upd_cnt = 0;
        drive(4'b1110, 8'h40, 3);
        drive(4'b1110, 8'h79, 15);
        #1;
        chk("t4_hex0", 32'(hex[3:0]), 32'h1);
        chk("t4_one_pulse", 32'(upd_cnt), 32'h1);

        // 5: illegal pattern on digit 2, sticky error
        upd_cnt = 0;
        drive(4'b1011, 8'h7F, 12);
        #1;
        chk("t5_err", 32'(pattern_err), 32'h1);
        chk("t5_valid2", 32'(digit_valid[2]), 32'h0);
        chk("t5_hex2", 32'(hex[11:8]), 32'h3);
        chk("t5_pulse", 32'(upd_cnt), 32'h1);
        drive(4'b1011, 8'hB0, 12);
        #1;
        chk("t5_err_sticky", 32'(pattern_err), 32'h1);
        chk("t5_valid2_back", 32'(digit_valid[2]), 32'h1);

`ifdef SEG7_TIMEOUT_EN
        // 6a: digit 3 captured then bus blanked; valid drops TIMEOUT cycles later
        t_cap = -1;
        t_drop = -1;
        selector = 4'b0111;
        signal = 8'hC0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (t_cap < 0 && update === 1'b1) t_cap = k;
            if (t_cap >= 0 && k == t_cap + 2) begin
                selector = 4'hF;
                signal = 8'hFF;
                upd_cnt = 0;
            end
            if (t_cap >= 0 && t_drop < 0 && digit_valid[3] === 1'b0) t_drop = k;
        end
        chk("t6_timeout_delay", 32'(t_drop - t_cap), 32'd50);
        chk("t6_hex3_held", 32'(hex[15:12]), 32'h0);
        chk("t6_no_pulse", 32'(upd_cnt), 32'h0);
`endif

        // Randomized bus activity
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 75) rsig = {1'($urandom_range(0, 1)), seg_tbl[$urandom_range(0, 15)]};
            else rsig = 8'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 10) rsel = 4'hF;
            else if (r < 20) rsel = 4'($urandom);
            else begin
                rsel = 4'hF;
                rsel[$urandom_range(0, 3)] = 1'b0;
            end
            drive(rsel, rsig, int'($urandom_range(1, 24)));
        end

        // 6b: reset mid-settle clears everything at once; no later pulse
        drive(4'b1110, 8'hF9, 12);
        drive(4'b1101, 8'h99, 4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_hex", 32'(hex), 32'h0);
        chk("t6_rst_dp", 32'(dp), 32'h0);
        chk("t6_rst_valid", 32'(digit_valid), 32'h0);
        chk("t6_rst_update", 32'(update), 32'h0);
        chk("t6_rst_err", 32'(pattern_err), 32'h0);
        selector = 4'hF;
        signal = 8'hFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        upd_cnt = 0;
        repeat (12) @(negedge clk);
        #1;
        chk("t6_no_update_after_rst", 32'(upd_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
